st_frame_capture: RTL and testbench



---
 rtl/video_stream_pkg.sv | 18 +
 rtl/rgb30_to_rgb12.sv | 15 +
 rtl/st_frame_capture.sv | 162 ++++++++++++++++
 tb/tb_st_frame_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_pkg.sv
// Shared types and field positions for the 30-bit RGB video stream path.
package video_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  // Top bit of each 10-bit channel inside a 30-bit pixel {R, G, B}
  localparam int R_HI = 29;
  localparam int G_HI = 19;
  localparam int B_HI = 9;

  typedef logic [29:0] pix30_t;
  typedef logic [11:0] pix12_t;

endpackage

// File: rtl/rgb30_to_rgb12.sv
// Combinational packer: keeps the upper 4 bits of each 10-bit channel (truncation, no rounding).
module rgb30_to_rgb12
  import video_stream_pkg::*;
(
  input  pix30_t pix_i,
  output pix12_t pix_o
);

  // Low channel bits are intentionally dropped by the 4-bit truncation.
  logic unused_low_bits;
  assign unused_low_bits = ^{pix_i[R_HI-4:G_HI+1], pix_i[G_HI-4:B_HI+1], pix_i[B_HI-4:0]};

  assign pix_o = {pix_i[R_HI -: 4], pix_i[G_HI -: 4], pix_i[B_HI -: 4]};

endmodule

// File: rtl/st_frame_capture.sv
// Avalon-ST video sink: writes each frame into a 12-bit frame-buffer RAM and
// checks packet length, flagging short, long and completed frames.
module st_frame_capture
  import video_stream_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [29:0]       sink_data,
  input  logic              sink_startofpacket,
  input  logic              sink_endofpacket,
  input  logic              sink_valid,
  output logic              sink_ready,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [11:0]       wrdata,
  output logic              frame_done,
  output logic              err_short,
  output logic              err_long,
  output logic [7:0]        frame_count,
  output logic              busy
);

  localparam int              N        = WIDTH * HEIGHT;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              sink_ready_q;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wraddress_q, wraddress_d;
  logic [11:0]       wrdata_q, wrdata_d;
  logic              frame_done_q, frame_done_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic [7:0]        frame_count_q, frame_count_d;

  logic              accept;
  logic              take;
  logic              restart;
  logic [ADDR_W:0]   idx;
  pix12_t            pix12;

  rgb30_to_rgb12 u_pack (
    .pix_i (sink_data),
    .pix_o (pix12)
  );

  assign accept = sink_valid & sink_ready_q;

  // Next-state logic: decide whether the accepted beat is written, where, and what it signals.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    wren_d        = 1'b0;
    wraddress_d   = wraddress_q;
    wrdata_d      = wrdata_q;
    frame_done_d  = 1'b0;
    err_short_d   = 1'b0;
    err_long_d    = 1'b0;
    frame_count_d = frame_count_q;
    take          = 1'b0;
    restart       = 1'b0;
    idx           = count_q;

    unique case (state_q)
      IDLE: begin
        if (accept && sink_startofpacket && enable) begin
          take = 1'b1;
          idx  = '0;
        end
      end
      CAPTURE: begin
        if (accept) begin
          take = 1'b1;
          if (sink_startofpacket) begin
            // A new SOP abandons the current frame and starts over at address 0.
            restart     = 1'b1;
            idx         = '0;
            err_short_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept) begin
          if (sink_startofpacket) begin
            take = 1'b1;
            idx  = '0;
          end else if (sink_endofpacket) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      wren_d      = 1'b1;
      wraddress_d = idx[ADDR_W-1:0];
      wrdata_d    = pix12;
      count_d     = idx + 1'b1;
      if (idx == LAST_IDX) begin
        if (sink_endofpacket && !restart) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          state_d       = IDLE;
        end else begin
          // Last address already used and no EOP: stop writing until the packet ends.
          err_long_d = 1'b1;
          state_d    = DRAIN;
        end
      end else if (sink_endofpacket && !restart) begin
        err_short_d = 1'b1;
        state_d     = IDLE;
      end else begin
        state_d = CAPTURE;
      end
    end
  end

  // State, counter and registered write-port / status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      sink_ready_q  <= 1'b0;
      wren_q        <= 1'b0;
      wraddress_q   <= '0;
      wrdata_q      <= '0;
      frame_done_q  <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      sink_ready_q  <= 1'b1;
      wren_q        <= wren_d;
      wraddress_q   <= wraddress_d;
      wrdata_q      <= wrdata_d;
      frame_done_q  <= frame_done_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign sink_ready  = sink_ready_q;
  assign wren        = wren_q;
  assign wraddress   = wraddress_q;
  assign wrdata      = wrdata_q;
  assign frame_done  = frame_done_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_st_frame_capture.sv
// Bench for st_frame_capture with a 4x2 frame (N=8).
module tb_st_frame_capture;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [29:0]   sink_data;
  logic          sink_startofpacket;
  logic          sink_endofpacket;
  logic          sink_valid;
  logic          sink_ready;
  logic          wren;
  logic [AW-1:0] wraddress;
  logic [11:0]   wrdata;
  logic          frame_done;
  logic          err_short;
  logic          err_long;
  logic [7:0]    frame_count;
  logic          busy;

  st_frame_capture #(.WIDTH(4), .HEIGHT(2), .ADDR_W(AW)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .sink_data          (sink_data),
    .sink_startofpacket (sink_startofpacket),
    .sink_endofpacket   (sink_endofpacket),
    .sink_valid         (sink_valid),
    .sink_ready         (sink_ready),
    .wren               (wren),
    .wraddress          (wraddress),
    .wrdata             (wrdata),
    .frame_done         (frame_done),
    .err_short          (err_short),
    .err_long           (err_long),
    .frame_count        (frame_count),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, sop, eop, en;
    logic [29:0] d;
    logic        wr;
    int          addr;
    logic [11:0] wd;
    logic        done, shrt, lng;
    logic        busy_after;
  } vec_t;

  typedef struct {
    int          addr;
    logic [11:0] wd;
    logic        done, shrt, lng;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [11:0] pack12(input logic [29:0] d);
    return {d[29:26], d[19:16], d[9:6]};
  endfunction

  function automatic vec_t mk(input logic v, sop, eop, en, input logic [29:0] d,
                              input logic wr, input int addr, input logic [11:0] wd,
                              input logic done, shrt, lng, busy_after);
    vec_t r;
    r.v = v; r.sop = sop; r.eop = eop; r.en = en; r.d = d;
    r.wr = wr; r.addr = addr; r.wd = wd;
    r.done = done; r.shrt = shrt; r.lng = lng; r.busy_after = busy_after;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write seen on the RAM port must match the oldest expected write.
  always @(negedge clk) begin
    if (wren === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=addr %0h required=no write", wraddress);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wraddress", 32'(wraddress), e.addr);
        chk("wrdata", 32'(wrdata), 32'(e.wd));
        chk("frame_done", 32'(frame_done), 32'(e.done));
        chk("err_short", 32'(err_short), 32'(e.shrt));
        chk("err_long", 32'(err_long), 32'(e.lng));
      end
    end else if ((frame_done | err_short | err_long) === 1'b1) begin
      chk("pulse_without_write", {29'd0, frame_done, err_short, err_long}, 32'd0);
    end
  end

  // Applies the table one beat per clock; busy is checked after each beat is clocked in.
  task automatic run_tbl();
    foreach (tbl[i]) begin
      sink_valid         = tbl[i].v;
      sink_startofpacket = tbl[i].sop;
      sink_endofpacket   = tbl[i].eop;
      enable             = tbl[i].en;
      sink_data          = tbl[i].d;
      if (tbl[i].wr) begin
        wr_t w;
        w.addr = tbl[i].addr; w.wd = tbl[i].wd;
        w.done = tbl[i].done; w.shrt = tbl[i].shrt; w.lng = tbl[i].lng;
        sb.push_back(w);
      end
      @(posedge clk); #1;
      chk("busy", 32'(busy), 32'(tbl[i].busy_after));
    end
    sink_valid = 1'b0; sink_startofpacket = 1'b0; sink_endofpacket = 1'b0;
    tbl.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  task automatic add_frame(input int n, input int eop_at, input logic [29:0] fixed, input logic rnd);
    for (int i = 0; i < n; i++) begin
      logic [29:0] d;
      d = rnd ? 30'($urandom) : fixed;
      tbl.push_back(mk(1, i == 0, i == eop_at, 1, d, i <= 7, i, pack12(d),
                       i == 7 && eop_at == 7, i == eop_at && eop_at < 7,
                       i == 7 && eop_at > 7, i != eop_at));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; sink_data = '0;
    sink_startofpacket = 1'b0; sink_endofpacket = 1'b0; sink_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_reset", 32'(sink_ready), 0);
    chk("wren_in_reset", 32'(wren), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(sink_ready), 1);
    chk("frame_count_after_reset", 32'(frame_count), 0);
    chk("busy_after_reset", 32'(busy), 0);

    // Nominal frame: R=0x3FF, G=0, B=0x200 packs to 0xF08
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, i == 0, i == 7, 1, {10'h3FF, 10'h000, 10'h200}, 1, i, 12'hF08,
                       i == 7, 0, 0, i != 7));
    run_tbl(); drain();
    chk("frame_count_nominal", 32'(frame_count), 1);

    // Gapped valid, varied data
    for (int i = 0; i < 8; i++) begin
      logic [29:0] d;
      d = 30'($urandom);
      tbl.push_back(mk(1, i == 0, i == 7, 1, d, 1, i, pack12(d), i == 7, 0, 0, i != 7));
      tbl.push_back(mk(0, 0, 0, 1, 30'h0, 0, 0, 12'h0, 0, 0, 0, i != 7));
    end
    run_tbl(); drain();
    chk("frame_count_gapped", 32'(frame_count), 2);

    // Short frame: EOP on beat 5
    add_frame(6, 5, 30'h0, 1'b1);
    run_tbl(); drain();
    chk("frame_count_short", 32'(frame_count), 2);

    // Long frame: 11 beats, EOP on beat 10; beats 8..10 must not be written
    add_frame(11, 10, 30'h0, 1'b1);
    run_tbl(); drain();
    chk("frame_count_long", 32'(frame_count), 2);

    // Restart on beat 3, then full frame; enable drops mid-frame without aborting it
    for (int j = 0; j < 11; j++) begin
      logic [29:0] d;
      int a;
      d = 30'($urandom);
      a = (j < 3) ? j : j - 3;
      tbl.push_back(mk(1, j == 0 || j == 3, j == 10, j < 5, d, 1, a, pack12(d),
                       j == 10, j == 3, 0, j != 10));
    end
    run_tbl(); drain();
    chk("frame_count_restart", 32'(frame_count), 3);

    // Non-SOP beat in IDLE is discarded; SOP with enable low is ignored
    tbl.push_back(mk(1, 0, 0, 1, 30'h3FFFFFFF, 0, 0, 12'h0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, i == 0, i == 7, 0, 30'h3FFFFFFF, 0, 0, 12'h0, 0, 0, 0, 0));
    run_tbl(); drain();
    chk("frame_count_gated", 32'(frame_count), 3);

    // Reset mid-frame after 4 pixels; the beat presented with reset must not be written
    add_frame(4, 7, 30'h0, 1'b1);
    run_tbl();
    reset = 1'b1;
    sink_valid = 1'b1; sink_data = 30'h2AAAAAAA;
    @(posedge clk); #1;
    chk("wren_reset_mid", 32'(wren), 0);
    chk("busy_reset_mid", 32'(busy), 0);
    chk("frame_count_reset_mid", 32'(frame_count), 0);
    chk("ready_reset_mid", 32'(sink_ready), 0);
    reset = 1'b0;
    sink_valid = 1'b0;
    @(posedge clk); #1;
    chk("wren_post_reset", 32'(wren), 0);
    chk("wraddress_post_reset", 32'(wraddress), 0);
    chk("wrdata_post_reset", 32'(wrdata), 0);
    chk("pulses_post_reset", {29'd0, frame_done, err_short, err_long}, 0);
    chk("ready_post_reset", 32'(sink_ready), 1);
    drain();
    add_frame(8, 7, 30'h0, 1'b1);
    run_tbl(); drain();
    chk("frame_count_fresh", 32'(frame_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
